// File: rtl/reg_pipe_stage.sv
// Elastic pipeline-stage register: DEPTH-entry FIFO with valid/ready handshake,
// synchronous reset/set that load programmable values onto dataout.
module reg_pipe_stage #(
    parameter int               WIDTH       = 9,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = 9'h004,
    parameter logic [WIDTH-1:0] SET_VALUE   = 9'h1FB
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         set,
    input  logic                         enable,
    input  logic [WIDTH-1:0]             datain,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             dataout,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             push;
    logic             pop;

    // Explicit wrap so non-power-of-2 depths never index past the last entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = enable & (count_q < CNT_FULL);
    assign out_valid = enable & (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;
    // When empty, show the last popped beat (or the reset/set value) so dataout is never X.
    assign dataout   = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            last_d   = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= RESET_VALUE;
        end else if (set) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= SET_VALUE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !set && push) begin
            mem_q[wr_ptr_q] <= datain;
        end
    end

endmodule

// File: tb/tb_reg_pipe_stage.sv
// Scoreboard bench for reg_pipe_stage: directed vectors on a DEPTH=2 stage,
// then in-order streaming through DEPTH=2, 3 and 1 stages side by side.
module tb_reg_pipe_stage;

    logic       clk;
    logic       reset;
    logic       set_s;
    logic       en;
    logic       mon_en;
    logic [8:0] din  [3];
    logic       iv   [3];
    logic       ordy [3];
    logic       ir   [3];
    logic       ov   [3];
    logic [8:0] dout [3];
    wire  [4:0] cnt_x [3];

    int total  = 0;
    int passed = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int D = (g == 0) ? 2 : (g == 1) ? 3 : 1;
        logic [$clog2(D+1)-1:0] cnt;
        logic [8:0]             q [$];
        logic [8:0]             last_exp = 9'h004;
        int                     npop = 0;

        reg_pipe_stage #(
            .WIDTH(9), .DEPTH(D), .RESET_VALUE(9'h004), .SET_VALUE(9'h1FB)
        ) u_dut (
            .clock(clk), .reset(reset), .set(set_s), .enable(en),
            .datain(din[g]), .in_valid(iv[g]), .in_ready(ir[g]),
            .dataout(dout[g]), .out_valid(ov[g]), .out_ready(ordy[g]),
            .count(cnt)
        );
        assign cnt_x[g] = 5'(cnt);

        // Stimulus side: record each accepted beat as the expected future output.
        initial forever begin
            @(negedge clk);
            #1;
            if (mon_en && !reset && !set_s && iv[g] && ir[g]) q.push_back(din[g]);
        end

        // Monitor: compare registered state to the model, consume beats on pop.
        initial forever begin
            int         sz;
            logic [8:0] exp_d;
            @(negedge clk);
            if (mon_en) begin
                sz    = q.size();
                exp_d = (sz != 0) ? q[0] : last_exp;
                chk($sformatf("d%0d_count", D), 32'(cnt_x[g]), 32'(sz));
                chk($sformatf("d%0d_in_ready", D), 32'(ir[g]), 32'(en && (sz < D)));
                chk($sformatf("d%0d_out_valid", D), 32'(ov[g]), 32'(en && (sz != 0)));
                chk($sformatf("d%0d_dataout", D), 32'(dout[g]), 32'(exp_d));
                if (reset) begin
                    q.delete();
                    last_exp = 9'h004;
                end else if (set_s) begin
                    q.delete();
                    last_exp = 9'h1FB;
                end else if (ov[g] && ordy[g] && sz != 0) begin
                    exp_d = q.pop_front();
                    chk($sformatf("d%0d_pop_data", D), 32'(dout[g]), 32'(exp_d));
                    last_exp = exp_d;
                    npop++;
                end
            end
        end
    end

    task automatic stream(input int g);
        int   beat  = 0;
        int   guard = 0;
        logic acc;
        while (beat < 40 && guard < 400) begin
            din[g]  = 9'(beat);
            iv[g]   = 1'b1;
            ordy[g] = 1'($urandom_range(0, 1));
            acc     = ir[g];
            tick();
            guard++;
            if (acc) beat++;
        end
        iv[g]   = 1'b0;
        ordy[g] = 1'b1;
        chk($sformatf("stream%0d_sent", g), 32'(beat), 32'd40);
    endtask

    int np0, np1, np2;

    initial begin
        reset  = 1'b1;
        set_s  = 1'b0;
        en     = 1'b1;
        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din[i]  = '0;
            iv[i]   = 1'b0;
            ordy[i] = 1'b0;
        end
        tick();
        reset  = 1'b0;
        mon_en = 1'b1;

        // reset then idle
        repeat (3) tick();
        chk("t1_dout", 32'(dout[0]), 32'h004);
        chk("t1_out_valid", 32'(ov[0]), 32'd0);
        chk("t1_count", 32'(cnt_x[0]), 32'd0);
        chk("t1_in_ready", 32'(ir[0]), 32'd1);

        // fill and drain
        iv[0] = 1'b1; din[0] = 9'h011; tick();
        din[0] = 9'h022; tick();
        iv[0] = 1'b0;
        chk("t2_full_count", 32'(cnt_x[0]), 32'd2);
        chk("t2_full_in_ready", 32'(ir[0]), 32'd0);
        chk("t2_full_dout", 32'(dout[0]), 32'h011);
        ordy[0] = 1'b1; tick();
        chk("t2_pop1_dout", 32'(dout[0]), 32'h022);
        chk("t2_pop1_count", 32'(cnt_x[0]), 32'd1);
        tick();
        ordy[0] = 1'b0;
        chk("t2_empty_count", 32'(cnt_x[0]), 32'd0);
        chk("t2_empty_dout", 32'(dout[0]), 32'h022);

        // full with simultaneous pop: push refused this edge, taken on the next
        iv[0] = 1'b1; din[0] = 9'h0AA; tick();
        din[0] = 9'h0BB; tick();
        din[0] = 9'h033; ordy[0] = 1'b1; tick();
        chk("t3_refused_count", 32'(cnt_x[0]), 32'd1);
        chk("t3_refused_dout", 32'(dout[0]), 32'h0BB);
        tick();
        chk("t3_accept_count", 32'(cnt_x[0]), 32'd1);
        chk("t3_accept_dout", 32'(dout[0]), 32'h033);
        iv[0] = 1'b0; tick();
        ordy[0] = 1'b0;
        chk("t3_drain_count", 32'(cnt_x[0]), 32'd0);

        // freeze
        iv[0] = 1'b1; din[0] = 9'h055; tick();
        en = 1'b0; din[0] = 9'h066; ordy[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_frz_out_valid", 32'(ov[0]), 32'd0);
            chk("t4_frz_in_ready", 32'(ir[0]), 32'd0);
            chk("t4_frz_count", 32'(cnt_x[0]), 32'd1);
            chk("t4_frz_dout", 32'(dout[0]), 32'h055);
        end
        en = 1'b1; iv[0] = 1'b0;
        #1;
        chk("t4_resume_out_valid", 32'(ov[0]), 32'd1);
        chk("t4_resume_in_ready", 32'(ir[0]), 32'd1);
        chk("t4_resume_dout", 32'(dout[0]), 32'h055);
        tick();
        ordy[0] = 1'b0;
        chk("t4_after_count", 32'(cnt_x[0]), 32'd0);
        chk("t4_after_dout", 32'(dout[0]), 32'h055);

        // set discards held beats and same-cycle push/pop; reset beats set
        iv[0] = 1'b1; din[0] = 9'h0C1; tick();
        din[0] = 9'h0C2; tick();
        chk("t5_pre_count", 32'(cnt_x[0]), 32'd2);
        set_s = 1'b1; din[0] = 9'h0EE; ordy[0] = 1'b1; tick();
        set_s = 1'b0; iv[0] = 1'b0; ordy[0] = 1'b0;
        chk("t5_set_count", 32'(cnt_x[0]), 32'd0);
        chk("t5_set_dout", 32'(dout[0]), 32'h1FB);
        chk("t5_set_out_valid", 32'(ov[0]), 32'd0);
        iv[0] = 1'b1; din[0] = 9'h0D1; tick();
        iv[0] = 1'b0;
        chk("t5_refill_count", 32'(cnt_x[0]), 32'd1);
        set_s = 1'b1; reset = 1'b1; tick();
        set_s = 1'b0; reset = 1'b0;
        chk("t5_both_dout", 32'(dout[0]), 32'h004);
        chk("t5_both_count", 32'(cnt_x[0]), 32'd0);

        // streaming through all three depths
        np0 = g_inst[0].npop;
        np1 = g_inst[1].npop;
        np2 = g_inst[2].npop;
        fork
            stream(0);
            stream(1);
            stream(2);
        join
        repeat (12) tick();
        chk("t6_d2_popped", 32'(g_inst[0].npop - np0), 32'd40);
        chk("t6_d3_popped", 32'(g_inst[1].npop - np1), 32'd40);
        chk("t6_d1_popped", 32'(g_inst[2].npop - np2), 32'd40);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t6_%0d_count", i), 32'(cnt_x[i]), 32'd0);
            chk($sformatf("t6_%0d_last", i), 32'(dout[i]), 32'd39);
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/reg_pipe_stage.md
Name: reg_pipe_stage

Overview:
- Parametrised elastic pipeline-stage register for the square-root datapath.
- Generalises the fixed 9-bit stage register in three ways:
  - configurable width;
  - per-bit reset and set values;
  - a DEPTH-entry buffer with a valid/ready handshake.
- Sits between pipeline stages so that one stage can stall without losing data in flight.

Parameters:
- WIDTH, 9, data width in bits.
- DEPTH, 2, number of buffer entries; legal range 1..16.
- RESET_VALUE, 9'h004, value driven on dataout after reset. The default matches the square-root seed, with bit 2 set.
- SET_VALUE, 9'h1FB, value driven on dataout after a set. This is the bitwise complement of RESET_VALUE.

Ports:
- clock  in  1  single rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- set  in  1  synchronous, active-high flush that loads SET_VALUE.
- enable  in  1  1 = stage runs; 0 = stage frozen.
- datain  in  WIDTH  input data.
- in_valid  in  1  datain is valid.
- in_ready  out  1  stage can accept a beat.
- dataout  out  WIDTH  data at the buffer head.
- out_valid  out  1  dataout holds a valid beat.
- out_ready  in  1  downstream accepts dataout.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Priority on each rising edge: reset > set > enable.
- Reset, when high at the edge:
  - buffer emptied; count=0, out_valid=0;
  - dataout=RESET_VALUE;
  - read/write pointers=0.
- Set, when high at the edge with reset low:
  - buffer emptied; count=0, out_valid=0;
  - dataout=SET_VALUE;
  - any push or pop in that cycle is discarded.
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Both are sampled at the edge.
- in_ready = enable & (count < DEPTH).
  - in_ready depends only on registered state and enable.
  - There is no combinational path from out_ready to in_ready.
  - When full, a simultaneous pop does not admit a push in the same cycle.
- out_valid = enable & (count != 0).
- enable=0 freezes the stage:
  - in_ready=0 and out_valid=0;
  - count, storage, pointers and dataout all hold.
  - Raising enable restores the previous out_valid and in_ready on the same cycle.
- Latency:
  - A beat pushed into an empty stage appears on dataout with out_valid=1 in the cycle after the push edge.
  - Through-flow is one beat per cycle while not full.
- Ordering is strict FIFO.
  - dataout is always the oldest entry.
  - Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged and advances both pointers.
- Pointer behaviour:
  - Pointers wrap modulo DEPTH.
  - When DEPTH is not a power of 2, each pointer wraps explicitly at DEPTH-1 → 0.
- Empty stage:
  - dataout holds the last popped value, or RESET_VALUE/SET_VALUE if none has been popped since the last reset/set.
  - No X is permitted on dataout.
- DEPTH=1 collapses the stage to a single-entry register with handshake. Its throughput is 1 beat per 2 cycles under continuous flow.
- A reset or set asserted mid-stream drops all held beats. No partial beat remains.
- Assertions the verifier checks:
  - count ≤ DEPTH at all times;
  - no push is accepted when count = DEPTH.

Test Plan:
1. Reset then idle:
   - Stimulus: reset=1 for 1 cycle, then idle 3 cycles.
   - Required: dataout=9'h004, out_valid=0, count=0, in_ready=1.
2. Fill and drain (DEPTH=2):
   - Stimulus: push 9'h011 and 9'h022 with out_ready=0.
   - Required after filling: count=2, in_ready=0, dataout=9'h011.
   - Stimulus: out_ready=1 for 2 cycles.
   - Required: pops 9'h011 then 9'h022; count=0; dataout holds 9'h022.
3. Full with simultaneous pop:
   - Stimulus: at count=2, assert in_valid=1 (datain=9'h033) and out_ready=1.
   - Required: 9'h033 is not accepted; count=1; 9'h033 is accepted on the next edge.
4. Freeze:
   - Stimulus: at count=1 with dataout=9'h055, drive enable=0 for 4 cycles with in_valid=1 and out_ready=1.
   - Required during the freeze: out_valid=0, in_ready=0, count=1, dataout=9'h055.
   - Required after enable returns to 1: 9'h055 pops first.
5. Set versus reset priority:
   - Stimulus: set=1 with count=2.
   - Required: count=0, dataout=9'h1FB.
   - Stimulus: set=1 and reset=1 together.
   - Required: dataout=9'h004.
6. Streaming, wrap and DEPTH variant:
   - Stimulus: 40 back-to-back beats 0..39 with out_ready toggling randomly.
   - Required: all beats emerge in order with no loss or duplication, and the pointers wrap.
   - Repeat with DEPTH=3 and with DEPTH=1; the same ordering requirement holds.
